// File: rtl/checkbits_run_monitor_if.sv
// checkbits_run_monitor_if: control, checkpoint bus, result and log-read signals of the run monitor.
interface checkbits_run_monitor_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 32
);
    logic              arm;
    logic              abort;
    logic [DATA_W-1:0] checkbits;
    logic [3:0]        rd_idx;
    logic              busy;
    logic              run_done;
    logic [CNT_W-1:0]  run_cycles;
    logic [3:0]        run_idx;
    logic              all_done;
    logic              timeout;
    logic [CNT_W-1:0]  rd_data;
    logic [CNT_W-1:0]  min_cycles;
    logic [CNT_W-1:0]  max_cycles;

    modport master (
        output arm, abort, checkbits, rd_idx,
        input  busy, run_done, run_cycles, run_idx, all_done, timeout,
               rd_data, min_cycles, max_cycles
    );

    modport slave (
        input  arm, abort, checkbits, rd_idx,
        output busy, run_done, run_cycles, run_idx, all_done, timeout,
               rd_data, min_cycles, max_cycles
    );
endinterface

// File: rtl/checkbits_run_monitor.sv
// checkbits_run_monitor: measures START_PAT..END_PAT run lengths on the checkpoint bus,
// logs NUM_RUNS results per session and flags a global cycle-budget timeout.
// Define CHKMON_STATS_EN to enable per-session min/max run statistics.
module checkbits_run_monitor #(
    parameter int unsigned       DATA_W      = 16,
    parameter logic [DATA_W-1:0] START_PAT   = DATA_W'(16'h00A5),
    parameter logic [DATA_W-1:0] END_PAT     = DATA_W'(16'hBF5A),
    parameter int unsigned       NUM_RUNS    = 3,
    parameter int unsigned       CNT_W       = 32,
    parameter int unsigned       TIMEOUT_CYC = 250000
) (
    input logic                     clock,
    input logic                     RSTB,
    checkbits_run_monitor_if.slave  bus
);
    localparam int unsigned LOG_DEPTH = 16;
    localparam int unsigned RUN_W     = 5;

    typedef enum logic [2:0] {IDLE, WAIT_START, MEASURE, DONE, TOUT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   gcnt_q, gcnt_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [CNT_W-1:0]   run_cycles_q, run_cycles_d;
    logic [3:0]         run_idx_q, run_idx_d;
    logic               run_done_q, run_done_d;
    logic               all_done_q, all_done_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic               log_we;
    logic [3:0]         log_wa;
    logic [CNT_W-1:0]   log_wd;
    logic               stats_clr;
    logic               final_end;
    logic               budget_hit;
    logic [CNT_W-1:0]   log_q [LOG_DEPTH];

    // Budget expires on the cycle the global counter holds TIMEOUT_CYC-1; 0 disables it.
    assign budget_hit = (TIMEOUT_CYC != 0) && (gcnt_q == CNT_W'(TIMEOUT_CYC - 1));

    // Next-state and datapath update; abort overrides everything, final completion beats timeout.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gcnt_d       = gcnt_q;
        run_d        = run_q;
        run_cycles_d = run_cycles_q;
        run_idx_d    = run_idx_q;
        run_done_d   = 1'b0;
        all_done_d   = all_done_q;
        timeout_d    = timeout_q;
        log_we       = 1'b0;
        log_wa       = 4'd0;
        log_wd       = '0;
        stats_clr    = 1'b0;
        final_end    = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, DONE, TOUT: begin
                    if (bus.arm) begin
                        state_d    = WAIT_START;
                        all_done_d = 1'b0;
                        timeout_d  = 1'b0;
                        run_d      = '0;
                        gcnt_d     = '0;
                        stats_clr  = 1'b1;
                    end
                end
                WAIT_START: begin
                    if (bus.checkbits == START_PAT) begin
                        state_d = MEASURE;
                        cnt_d   = '0;
                    end
                end
                MEASURE: begin
                    if (bus.checkbits == END_PAT) begin
                        log_we       = 1'b1;
                        log_wa       = run_q[3:0];
                        log_wd       = cnt_q;
                        run_cycles_d = cnt_q;
                        run_idx_d    = run_q[3:0];
                        run_done_d   = 1'b1;
                        run_d        = run_q + RUN_W'(1);
                        if (run_q == RUN_W'(NUM_RUNS - 1)) begin
                            state_d    = DONE;
                            all_done_d = 1'b1;
                            final_end  = 1'b1;
                        end else begin
                            state_d = WAIT_START;
                        end
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase

            if (state_q == WAIT_START || state_q == MEASURE) begin
                gcnt_d = gcnt_q + CNT_W'(1);
                if (budget_hit && !final_end) begin
                    state_d   = TOUT;
                    timeout_d = 1'b1;
                end
            end
        end

        busy_d = (state_d == WAIT_START) || (state_d == MEASURE);
    end

    // State and result registers.
    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            gcnt_q       <= '0;
            run_q        <= '0;
            run_cycles_q <= '0;
            run_idx_q    <= 4'd0;
            run_done_q   <= 1'b0;
            all_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gcnt_q       <= gcnt_d;
            run_q        <= run_d;
            run_cycles_q <= run_cycles_d;
            run_idx_q    <= run_idx_d;
            run_done_q   <= run_done_d;
            all_done_q   <= all_done_d;
            timeout_q    <= timeout_d;
            busy_q       <= busy_d;
        end
    end

    // Run log; survives abort and re-arm, cleared only by reset.
    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            for (int i = 0; i < LOG_DEPTH; i++) begin
                log_q[i] <= '0;
            end
        end else if (log_we) begin
            log_q[log_wa] <= log_wd;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.run_done   = run_done_q;
    assign bus.run_cycles = run_cycles_q;
    assign bus.run_idx    = run_idx_q;
    assign bus.all_done   = all_done_q;
    assign bus.timeout    = timeout_q;
    assign bus.rd_data    = (32'(bus.rd_idx) < NUM_RUNS) ? log_q[bus.rd_idx] : '0;

`ifdef CHKMON_STATS_EN
    logic [CNT_W-1:0] min_q, max_q;

    // Session min/max, updated alongside the log write.
    always_ff @(posedge clock or negedge RSTB) begin
        if (!RSTB) begin
            min_q <= '1;
            max_q <= '0;
        end else if (stats_clr) begin
            min_q <= '1;
            max_q <= '0;
        end else if (log_we) begin
            if (log_wd < min_q) min_q <= log_wd;
            if (log_wd > max_q) max_q <= log_wd;
        end
    end

    assign bus.min_cycles = min_q;
    assign bus.max_cycles = max_q;
`else
    logic unused_stats;
    assign unused_stats   = stats_clr;
    assign bus.min_cycles = '0;
    assign bus.max_cycles = '0;
`endif
endmodule

// File: tb/tb_checkbits_run_monitor.sv
// tb_checkbits_run_monitor: directed and random stimulus against a run-level reference model.
module tb_checkbits_run_monitor;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned CNT_W    = 32;
    localparam int unsigned NUM_RUNS = 3;
    localparam int unsigned TO       = 100;
    localparam logic [15:0] SP       = 16'h00A5;
    localparam logic [15:0] EP       = 16'hBF5A;
    localparam logic [15:0] FILL     = 16'h1234;
`ifdef CHKMON_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clock;
    logic RSTB;
    int   n_tests;
    int   n_fail;

    checkbits_run_monitor_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus_if ();

    checkbits_run_monitor #(
        .DATA_W(DATA_W), .START_PAT(SP), .END_PAT(EP), .NUM_RUNS(NUM_RUNS),
        .CNT_W(CNT_W), .TIMEOUT_CYC(TO)
    ) dut (
        .clock(clock),
        .RSTB (RSTB),
        .bus  (bus_if)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: session/run bookkeeping in terms of edges since arm.
    bit          m_busy, m_in_run, m_all_done, m_timeout, m_run_done;
    logic [31:0] m_len, m_last, m_min, m_max;
    logic [3:0]  m_last_idx;
    int          m_runs;
    longint      m_edge, m_arm_edge;
    logic [31:0] m_log [16];

    task automatic model_reset();
        m_busy = 0; m_in_run = 0; m_all_done = 0; m_timeout = 0; m_run_done = 0;
        m_len = 0; m_last = 0; m_last_idx = 0; m_runs = 0;
        m_min = '1; m_max = 0; m_arm_edge = 0;
        for (int i = 0; i < 16; i++) m_log[i] = 0;
    endtask

    task automatic model_edge(input logic a, input logic ab, input logic [15:0] cb);
        bit was_busy;
        bit finished;
        m_edge++;
        m_run_done = 0;
        if (ab) begin
            m_busy = 0;
            return;
        end
        was_busy = m_busy;
        finished = 0;
        if (!m_busy) begin
            if (a) begin
                m_busy = 1; m_in_run = 0; m_all_done = 0; m_timeout = 0;
                m_runs = 0; m_min = '1; m_max = 0; m_arm_edge = m_edge;
            end
        end else if (!m_in_run) begin
            if (cb == SP) begin
                m_in_run = 1;
                m_len = 0;
            end
        end else if (cb == EP) begin
            m_log[m_runs] = m_len;
            m_last = m_len;
            m_last_idx = 4'(m_runs);
            m_run_done = 1;
            if (m_len < m_min) m_min = m_len;
            if (m_len > m_max) m_max = m_len;
            m_runs++;
            m_in_run = 0;
            if (m_runs == NUM_RUNS) begin
                m_busy = 0; m_all_done = 1; finished = 1;
            end
        end else if (m_len != '1) begin
            m_len++;
        end
        if (was_busy && !finished && (m_edge - m_arm_edge) == longint'(TO)) begin
            m_busy = 0;
            m_timeout = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string pfx);
        logic [31:0] exp_rd;
        exp_rd = (bus_if.rd_idx < 4'(NUM_RUNS)) ? m_log[bus_if.rd_idx] : 32'd0;
        chk({pfx, ".busy"},       64'(bus_if.busy),       64'(m_busy));
        chk({pfx, ".run_done"},   64'(bus_if.run_done),   64'(m_run_done));
        chk({pfx, ".run_cycles"}, 64'(bus_if.run_cycles), 64'(m_last));
        chk({pfx, ".run_idx"},    64'(bus_if.run_idx),    64'(m_last_idx));
        chk({pfx, ".all_done"},   64'(bus_if.all_done),   64'(m_all_done));
        chk({pfx, ".timeout"},    64'(bus_if.timeout),    64'(m_timeout));
        chk({pfx, ".rd_data"},    64'(bus_if.rd_data),    64'(exp_rd));
        chk({pfx, ".min"},        64'(bus_if.min_cycles), STATS ? 64'(m_min) : 64'd0);
        chk({pfx, ".max"},        64'(bus_if.max_cycles), STATS ? 64'(m_max) : 64'd0);
    endtask

    task automatic cyc(input logic a, input logic ab, input logic [15:0] cb,
                       input logic [3:0] ri, input string pfx);
        bus_if.arm = a; bus_if.abort = ab; bus_if.checkbits = cb; bus_if.rd_idx = ri;
        @(posedge clock);
        model_edge(a, ab, cb);
        #1;
        check_all(pfx);
    endtask

    task automatic set_rd(input logic [3:0] ri);
        bus_if.rd_idx = ri;
        #1;
    endtask

    initial begin
        logic [15:0] cb;
        int          lens [3];
        n_tests = 0; n_fail = 0; m_edge = 0;
        bus_if.arm = 0; bus_if.abort = 0; bus_if.checkbits = 0; bus_if.rd_idx = 0;
        RSTB = 1'b0;
        model_reset();
        #2;
        chk("rst.busy",     64'(bus_if.busy),       64'd0);
        chk("rst.all_done", 64'(bus_if.all_done),   64'd0);
        chk("rst.min",      64'(bus_if.min_cycles), STATS ? 64'hFFFF_FFFF : 64'd0);
        chk("rst.max",      64'(bus_if.max_cycles), 64'd0);
        #10 RSTB = 1'b1;

        // Test 1: single run with 7 intervening cycles.
        cyc(1, 0, 16'h0000, 0, "t1.arm");
        cyc(0, 0, SP, 0, "t1.start");
        for (int i = 0; i < 7; i++) cyc(0, 0, FILL, 0, "t1.fill");
        cyc(0, 0, EP, 0, "t1.end");
        chk("t1.run_done",   64'(bus_if.run_done),   64'd1);
        chk("t1.run_cycles", 64'(bus_if.run_cycles), 64'd7);
        chk("t1.run_idx",    64'(bus_if.run_idx),    64'd0);
        chk("t1.busy",       64'(bus_if.busy),       64'd1);
        cyc(0, 0, 16'h0000, 0, "t1.after");
        chk("t1.pulse_low",  64'(bus_if.run_done),   64'd0);
        cyc(0, 1, 16'h0000, 0, "t1.abort");

        // Test 2: three runs of 5, 0 and 40 cycles.
        lens = '{5, 0, 40};
        cyc(1, 0, 16'h0000, 0, "t2.arm");
        for (int r = 0; r < 3; r++) begin
            cyc(0, 0, SP, 0, "t2.start");
            for (int i = 0; i < lens[r]; i++) cyc(0, 0, FILL, 0, "t2.fill");
            cyc(0, 0, EP, 0, "t2.end");
            chk("t2.run_cycles", 64'(bus_if.run_cycles), 64'(lens[r]));
            if (r < 2) cyc(0, 0, 16'h0000, 0, "t2.gap");
        end
        chk("t2.all_done", 64'(bus_if.all_done), 64'd1);
        chk("t2.busy",     64'(bus_if.busy),     64'd0);
        set_rd(0); chk("t2.rd0", 64'(bus_if.rd_data), 64'd5);
        set_rd(1); chk("t2.rd1", 64'(bus_if.rd_data), 64'd0);
        set_rd(2); chk("t2.rd2", 64'(bus_if.rd_data), 64'd40);
        set_rd(3); chk("t2.rd3", 64'(bus_if.rd_data), 64'd0);
        chk("t2.min", 64'(bus_if.min_cycles), 64'd0);
        chk("t2.max", 64'(bus_if.max_cycles), STATS ? 64'd40 : 64'd0);

        // Test 3: no END_PAT; timeout exactly TO cycles after arm.
        cyc(1, 0, 16'h0000, 0, "t3.arm");
        for (int k = 1; k <= 100; k++) begin
            cyc(0, 0, (k == 1) ? SP : FILL, 0, "t3.run");
            if (k == 99) chk("t3.pre_timeout", 64'(bus_if.timeout), 64'd0);
        end
        chk("t3.timeout",  64'(bus_if.timeout),  64'd1);
        chk("t3.busy",     64'(bus_if.busy),     64'd0);
        chk("t3.all_done", 64'(bus_if.all_done), 64'd0);

        // Test 4: final END_PAT on the budget-expiry edge.
        cyc(1, 0, 16'h0000, 0, "t4.arm");
        cyc(0, 0, SP, 0, "t4.s0"); cyc(0, 0, EP, 0, "t4.e0");
        cyc(0, 0, SP, 0, "t4.s1"); cyc(0, 0, EP, 0, "t4.e1");
        cyc(0, 0, SP, 0, "t4.s2");
        for (int k = 6; k <= 99; k++) cyc(0, 0, FILL, 0, "t4.fill");
        cyc(0, 0, EP, 0, "t4.e2");
        chk("t4.all_done",   64'(bus_if.all_done),   64'd1);
        chk("t4.timeout",    64'(bus_if.timeout),    64'd0);
        chk("t4.run_cycles", 64'(bus_if.run_cycles), 64'd94);

        // Test 5: abort mid-MEASURE, then async reset mid-WAIT_START.
        cyc(1, 0, 16'h0000, 2, "t5.arm");
        cyc(0, 0, SP, 2, "t5.start");
        cyc(0, 0, FILL, 2, "t5.fill");
        cyc(0, 1, FILL, 2, "t5.abort");
        chk("t5.busy",    64'(bus_if.busy),    64'd0);
        chk("t5.log_kept", 64'(bus_if.rd_data), 64'd94);
        cyc(1, 0, 16'h0000, 2, "t5.rearm");
        cyc(0, 0, 16'h0000, 2, "t5.wait");
        RSTB = 1'b0;
        model_reset();
        #1;
        check_all("t5.rst");
        chk("t5.rst_log", 64'(bus_if.rd_data), 64'd0);
        #2 RSTB = 1'b1;

        // Test 6: END_PAT ignored in WAIT_START, START_PAT ignored in MEASURE.
        cyc(1, 0, 16'h0000, 0, "t6.arm");
        cyc(0, 0, EP, 0, "t6.stray_end");
        chk("t6.no_done", 64'(bus_if.run_done), 64'd0);
        cyc(0, 0, SP, 0, "t6.start");
        cyc(0, 0, SP, 0, "t6.start_again");
        cyc(0, 0, EP, 0, "t6.end");
        chk("t6.run_cycles", 64'(bus_if.run_cycles), 64'd1);

        // Random phase against the reference model.
        for (int n = 0; n < 3000; n++) begin
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r < 3)      cb = SP;
            else if (r < 6) cb = EP;
            else            cb = 16'($urandom);
            cyc(($urandom_range(0, 19) == 0), ($urandom_range(0, 99) == 0), cb,
                4'($urandom_range(0, 15)), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/checkbits_run_monitor.md
Name: checkbits_run_monitor

Overview:
Synthesizable, parametrised monitor for the mprj checkbits bus. It detects a start marker and an end marker on a DATA_W-bit checkpoint bus and measures the cycle count of each run. It repeats this for NUM_RUNS runs, logs each result and flags a global timeout. It sits beside the user project, or in a bench harness, on mprj_io[31:16], and replaces ad-hoc wait/while loops with a reusable, readable measurement block.

Parameters:
- DATA_W, 16, checkpoint bus width.
- START_PAT, 16'h00A5, start marker; width DATA_W.
- END_PAT, 16'hBF5A, end marker; width DATA_W.
- NUM_RUNS, 3, runs measured before all_done; range 1..16.
- CNT_W, 32, cycle counter and log entry width.
- TIMEOUT_CYC, 250000, global cycle budget counted from arm; 0 disables the timeout.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- RSTB, input, 1, asynchronous active-low reset.
- arm, input, 1, one-cycle pulse that starts a measurement session.
- abort, input, 1, synchronous return to IDLE; the log is kept.
- checkbits, input, DATA_W, monitored bus; sampled every posedge, no internal synchroniser.
- busy, output, 1, high in WAIT_START or MEASURE.
- run_done, output, 1, one-cycle pulse when a run's END_PAT is sampled.
- run_cycles, output, CNT_W, cycle count of the last completed run.
- run_idx, output, 4, index (0-based) of the last completed run.
- all_done, output, 1, sticky; NUM_RUNS runs completed.
- timeout, output, 1, sticky; budget expired before all_done.
- rd_idx, input, 4, log read index.
- rd_data, output, CNT_W, log[rd_idx], combinational; 0 if rd_idx >= NUM_RUNS.
- min_cycles, output, CNT_W, statistics output (see Optional Feature).
- max_cycles, output, CNT_W, statistics output (see Optional Feature).

Behaviour:
- Reset (RSTB=0, asynchronous): state=IDLE.
  - busy, run_done, all_done and timeout are 0.
  - run_cycles, run_idx, the run counter, the cycle counter, the global counter and all log entries are 0.
  - min_cycles is all-ones; max_cycles is 0.
- States:
  - IDLE: arm goes to WAIT_START. Arming clears all_done, timeout, the run counter, the global counter and the stats. The log is not cleared.
  - WAIT_START: checkbits==START_PAT goes to MEASURE with the cycle counter set to 0.
  - MEASURE: each posedge, if checkbits==END_PAT:
    - log[run]=cnt, run_cycles=cnt, run_idx=run, pulse run_done, run++.
    - If run was NUM_RUNS-1, go to DONE; otherwise go to WAIT_START.
    - Otherwise (not END_PAT), cnt increments and saturates at all-ones.
  - DONE: all_done=1, busy=0. arm restarts the session.
  - TOUT: timeout=1, busy=0. arm restarts the session.
- Latency: END_PAT sampled on the cycle right after the START_PAT sample gives run_cycles=0. N intervening non-END cycles give N. run_done asserts in the cycle following the sampling edge (registered).
- A re-start requires START_PAT to be sampled again after END_PAT. START_PAT seen during MEASURE is ignored, and so is END_PAT seen during WAIT_START.
- Global counter: increments every cycle while busy.
  - When TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 while busy, the next state is TOUT.
  - If END_PAT on the final run and timeout expiry fall on the same cycle, completion wins: DONE, timeout=0.
- abort has priority over every transition except reset. It goes to IDLE with busy=0 and does not set all_done or timeout.
- arm outside IDLE/DONE/TOUT is ignored.
- arm and abort asserted in the same cycle: abort wins.

Optional Feature:
- Macro CHKMON_STATS_EN.
- Defined: min_cycles and max_cycles track the min and max of run_cycles over the current session, updated in the same cycle as the log write. Arming resets them to all-ones and 0.
- Undefined: no stats registers; min_cycles and max_cycles are tied to 0.

Test Plan:
1. Reset, then arm; drive 00A5 for one cycle, then 7 cycles of 0x1234, then BF5A. Required: run_done pulse, run_cycles=7, run_idx=0, busy=1.
2. Three runs of 5, 0 and 40 intermediate cycles, with 0x0000 between runs. Required: run_cycles 5/0/40, all_done=1, busy=0, rd_data at idx 0/1/2 = 5/0/40, rd_idx=3 gives 0. With CHKMON_STATS_EN: min=0, max=40.
3. TIMEOUT_CYC=100; arm and drive 00A5, never BF5A. Required: timeout=1 exactly 100 cycles after arm, busy=0, all_done=0.
4. Final run's BF5A coincides with budget expiry (TIMEOUT_CYC tuned to match). Required: all_done=1, timeout=0.
5. Assert abort mid-MEASURE, then pulse RSTB low asynchronously mid-WAIT_START. Required: IDLE after abort with the log intact; everything at reset values immediately on RSTB low.
6. During WAIT_START, drive BF5A, then 00A5, then 00A5, then BF5A. Required: the first BF5A is ignored and run_cycles=1.
